tlc_phase_timer: RTL and testbench
==================================

# tlc_phase_timer

Timing and sensor front-end for the traffic-light controller FSM, sitting directly upstream of it. It conditions the raw farm-road car sensor into a clean `x` and generates the one-cycle `en` advance pulses. It derives per-phase dwell times by watching the FSM's own `hwy`/`fwy` light codes fed back to it. The block enforces minimum green, fixed yellow, and maximum farm-road green durations, so the FSM itself stays untimed.

## Interface
Parameters:
- `CLK_DIV`, default 50_000_000: clk cycles per one-second tick; must be ≥ 2.
- `GREEN_MIN_S`, default 10: minimum highway-green dwell, in seconds.
- `YELLOW_S`, default 3: yellow dwell for both roads, in seconds.
- `FWY_MIN_S`, default 2: minimum farm-road-green dwell, in seconds.
- `FWY_MAX_S`, default 8: maximum farm-road-green dwell, in seconds; must be > `FWY_MIN_S`.
- `DEB_CYCLES`, default 16: number of consecutive stable clk cycles needed to accept a sensor change; must be ≥ 1.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `car_raw`  in  1  asynchronous farm-road car sensor.
- `hwy`  in  2  highway light code from the FSM (0 = YELLOW, 1 = RED, 2 = GREEN).
- `fwy`  in  2  farm-road light code from the FSM, same encoding.
- `x`  out  1  conditioned car-present signal to the FSM.
- `en`  out  1  one-cycle FSM advance strobe.
- `sec_tick`  out  1  one-cycle one-second strobe.
- `dwell`  out  8  seconds elapsed in the current phase; saturates at 255.
- `phase_err`  out  1  the current `hwy`/`fwy` pair is not a legal phase.

## Operation
- Phase decode of `{hwy,fwy}`:
  - GREEN/RED = HG
  - YELLOW/RED = HY
  - RED/GREEN = FG
  - RED/YELLOW = FY
  - any other pair = ILLEGAL
- Phase register `ph_q` is loaded with the decoded phase every cycle.
- Phase change: when the decoded phase ≠ `ph_q`, the next edge clears both the prescaler and `dwell` to 0. This takes priority over a coincident `sec_tick`.
- Prescaler counts 0..`CLK_DIV`-1 and wraps. `sec_tick` = (prescaler == `CLK_DIV`-1).
- `dwell` increments on each edge where `sec_tick`=1, saturating at 255.
- `en` is registered. On an edge where `sec_tick`=1, `en` <= condition evaluated on the incremented dwell value d'. On every other edge, `en` <= 0. Conditions per phase:
  - HG: d' ≥ `GREEN_MIN_S` (repeats every second; the FSM leaves HG only when `x`=1).
  - HY: d' ≥ `YELLOW_S`.
  - FG: d' ≥ `FWY_MIN_S`.
  - FY: d' ≥ `YELLOW_S`.
  - ILLEGAL: never.
- Sensor path:
  - `car_raw` passes through a 2-FF synchronizer, giving `s`.
  - Debounce counter: increments while `s` ≠ `x_deb`. When it equals `DEB_CYCLES`-1 and `s` ≠ `x_deb`, then `x_deb` <= `s` and the counter <= 0. When `s` == `x_deb`, the counter <= 0.
- Max-green force: `x` <= `x_deb` & ~(phase == FG & `dwell` ≥ `FWY_MAX_S`), registered. Forcing `x` low makes the next FG `en` move the FSM to FY.
- `phase_err` <= (decoded phase == ILLEGAL), registered. While ILLEGAL, `dwell` is held at 0 and the prescaler keeps running.

## Timing
- Reset values: `x`=0, `en`=0, `phase_err`=0, `dwell`=0, prescaler=0. The synchronizer FFs, `x_deb` and the debounce counter are also 0. `ph_q`=HG, matching the FSM's reset phase of HG.
- `sec_tick` first asserts in cycle `CLK_DIV`-1 after reset release or after a phase-change clear, counting the first post-clear cycle as cycle 0.
- `en` is high exactly one cycle, namely the cycle after a `sec_tick`. The FSM changes state at the edge ending the `en` cycle.
- The new phase is seen one cycle after that edge, and the clear takes effect at the following edge. Because `CLK_DIV` ≥ 2, no second `en` can occur before the clear.
- Sensor latency: a stable change on `car_raw` reaches `x` after exactly `DEB_CYCLES`+3 edges. Any pulse on `s` shorter than `DEB_CYCLES` cycles never reaches `x`.
- `dwell` saturates at 255: no wrap, and `en` conditions stay true while saturated.
- Asynchronous reset mid-phase clears all state immediately. No `en` is emitted until the thresholds are met again.

## Test plan
Parameters for all tests: `CLK_DIV`=4, `GREEN_MIN_S`=3, `YELLOW_S`=2, `FWY_MIN_S`=2, `FWY_MAX_S`=5, `DEB_CYCLES`=3.
- Reset release, phase held at HG, `car_raw`=0 → `sec_tick` in cycles 3, 7, 11, 15. `en` high only in cycles 12 and 16, one cycle each. `x` stays 0 and `dwell` reaches 4.
- `car_raw` rises and stays high → `x` rises 6 edges later. A 2-cycle `car_raw` pulse leaves `x` at 0.
- Drive HY after `en` (emulating the FSM) → `dwell` clears to 0 within 2 cycles. `en` fires once, 1 cycle after the 2nd `sec_tick` of HY.
- FG with `car_raw` held at 1 → `x`=1 until `dwell`=5, then `x`=0 one cycle later. The next `sec_tick` produces `en`=1.
- `{hwy,fwy}` = RED/RED for 20 cycles → `phase_err`=1 one cycle later, `dwell`=0, no `en`. Returning to HG clears `phase_err`.
- Assert `rstn`=0 mid-FY, 1 cycle before `en` is due → `en`, `x` and `dwell` go to 0 immediately, with no `en` until timing restarts.

Source files
------------

// File: rtl/tlc_phase_timer.sv
// tlc_phase_timer: timing and sensor front-end for the traffic-light FSM.
// Derives the current phase from the FSM's own light codes, times each phase
// in seconds, emits one-cycle advance strobes once a phase's dwell is met,
// and conditions the raw farm-road car sensor (sync + debounce + max-green).
//
// phase  | meaning
// -------+----------------------------------------------
// PH_HG  | highway green, farm road red
// PH_HY  | highway yellow, farm road red
// PH_FG  | highway red, farm road green
// PH_FY  | highway red, farm road yellow
// PH_ILL | any other light pair (dwell held at 0, no en)
module tlc_phase_timer #(
    parameter int CLK_DIV     = 50_000_000,
    parameter int GREEN_MIN_S = 10,
    parameter int YELLOW_S    = 3,
    parameter int FWY_MIN_S   = 2,
    parameter int FWY_MAX_S   = 8,
    parameter int DEB_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       car_raw,
    input  logic [1:0] hwy,
    input  logic [1:0] fwy,
    output logic       x,
    output logic       en,
    output logic       sec_tick,
    output logic [7:0] dwell,
    output logic       phase_err
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DW = $clog2(DEB_CYCLES + 1);

    localparam logic [1:0] L_YEL = 2'd0;
    localparam logic [1:0] L_RED = 2'd1;
    localparam logic [1:0] L_GRN = 2'd2;

    typedef enum logic [2:0] {
        PH_HG  = 3'd0,
        PH_HY  = 3'd1,
        PH_FG  = 3'd2,
        PH_FY  = 3'd3,
        PH_ILL = 3'd4
    } phase_t;

    phase_t          ph_q;
    phase_t          ph_d;
    logic            ph_chg;
    logic [PW-1:0]   presc;
    logic [7:0]      dwell_inc;
    logic            en_cond;
    logic            x_force;

    logic            sync1;
    logic            s;
    logic            x_deb;
    logic [DW-1:0]   deb_cnt;

    // Decode the light pair fed back from the FSM into a phase.
    always_comb begin
        ph_d = PH_ILL;
        case ({hwy, fwy})
            {L_GRN, L_RED}: ph_d = PH_HG;
            {L_YEL, L_RED}: ph_d = PH_HY;
            {L_RED, L_GRN}: ph_d = PH_FG;
            {L_RED, L_YEL}: ph_d = PH_FY;
            default:        ph_d = PH_ILL;
        endcase
    end

    // Phase register; resets to HG to match the FSM's reset phase.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ph_q <= PH_HG;
        else       ph_q <= ph_d;
    end

    assign ph_chg   = (ph_d != ph_q);
    assign sec_tick = (presc == PW'(CLK_DIV - 1));

    // Incremented dwell and per-phase advance condition on that value.
    always_comb begin
        dwell_inc = (dwell == 8'hFF) ? dwell : dwell + 8'd1;
        en_cond   = 1'b0;
        case (ph_d)
            PH_HG:   en_cond = (dwell_inc >= 8'(GREEN_MIN_S));
            PH_HY:   en_cond = (dwell_inc >= 8'(YELLOW_S));
            PH_FG:   en_cond = (dwell_inc >= 8'(FWY_MIN_S));
            PH_FY:   en_cond = (dwell_inc >= 8'(YELLOW_S));
            default: en_cond = 1'b0;
        endcase
    end

    // One-second prescaler; a phase change restarts it so dwell counts
    // whole seconds from the start of the phase.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)         presc <= '0;
        else if (ph_chg)   presc <= '0;
        else if (sec_tick) presc <= '0;
        else               presc <= presc + PW'(1);
    end

    // Seconds in phase, saturating; held at 0 while the light pair is illegal.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                dwell <= 8'd0;
        else if (ph_chg)          dwell <= 8'd0;
        else if (ph_d == PH_ILL)  dwell <= 8'd0;
        else if (sec_tick)        dwell <= dwell_inc;
    end

    // Advance strobe: only ever one cycle wide, right after a second tick.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) en <= 1'b0;
        else       en <= sec_tick & en_cond;
    end

    // Two-flop synchronizer for the asynchronous car sensor.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= car_raw;
            s     <= sync1;
        end
    end

    // Debounce: accept a new sensor level only after DEB_CYCLES stable cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_deb   <= 1'b0;
            deb_cnt <= '0;
        end else if (s == x_deb) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
            x_deb   <= s;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + DW'(1);
        end
    end

    // Hide the car once farm-road green has run its maximum, so the next
    // FG strobe sends the FSM on to yellow.
    assign x_force = (ph_d == PH_FG) && (dwell >= 8'(FWY_MAX_S));

    // Registered outputs to the FSM: conditioned car flag and phase error.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x         <= 1'b0;
            phase_err <= 1'b0;
        end else begin
            x         <= x_deb & ~x_force;
            phase_err <= (ph_d == PH_ILL);
        end
    end

endmodule

// File: tb/tb_tlc_phase_timer.sv
// Bench for tlc_phase_timer: emulates the FSM's light codes and checks
// tick/strobe timing, sensor conditioning, max-green, illegal phase, reset.
module tb_tlc_phase_timer;

    localparam int CLK_DIV     = 4;
    localparam int GREEN_MIN_S = 3;
    localparam int YELLOW_S    = 2;
    localparam int FWY_MIN_S   = 2;
    localparam int FWY_MAX_S   = 5;
    localparam int DEB_CYCLES  = 3;

    localparam logic [1:0] YEL = 2'd0;
    localparam logic [1:0] RED = 2'd1;
    localparam logic [1:0] GRN = 2'd2;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       car_raw = 1'b0;
    logic [1:0] hwy = GRN;
    logic [1:0] fwy = RED;
    logic       x;
    logic       en;
    logic       sec_tick;
    logic [7:0] dwell;
    logic       phase_err;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_en[$];
    int exp_tick[$];
    int exp_lat[$];

    tlc_phase_timer #(
        .CLK_DIV(CLK_DIV), .GREEN_MIN_S(GREEN_MIN_S), .YELLOW_S(YELLOW_S),
        .FWY_MIN_S(FWY_MIN_S), .FWY_MAX_S(FWY_MAX_S), .DEB_CYCLES(DEB_CYCLES)
    ) dut (
        .clk(clk), .rstn(rstn), .car_raw(car_raw), .hwy(hwy), .fwy(fwy),
        .x(x), .en(en), .sec_tick(sec_tick), .dwell(dwell), .phase_err(phase_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rstn = 1'b0; hwy = GRN; fwy = RED; car_raw = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({x, en, phase_err, sec_tick, dwell} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got x=%b en=%b err=%b tick=%b dwell=%0d, want all 0",
                     x, en, phase_err, sec_tick, dwell);
        end
        rstn = 1'b1;
        #1;
    endtask

    task automatic test_hg_timing();
        int e;
        bit bad_x = 0;
        exp_tick = '{3, 7, 11, 15};
        exp_en   = '{12, 16};
        for (int c = 0; c <= 16; c++) begin
            if (c > 0) @(negedge clk);
            if (sec_tick) begin
                n_checks++;
                if (exp_tick.size() == 0) begin
                    n_fail++; $display("FAIL hg_tick: unexpected tick at cycle %0d", c);
                end else begin
                    e = exp_tick.pop_front();
                    if (c !== e) begin
                        n_fail++; $display("FAIL hg_tick: tick at cycle %0d, want %0d", c, e);
                    end
                end
            end
            if (en) begin
                n_checks++;
                if (exp_en.size() == 0) begin
                    n_fail++; $display("FAIL hg_en: unexpected en at cycle %0d", c);
                end else begin
                    e = exp_en.pop_front();
                    if (c !== e) begin
                        n_fail++; $display("FAIL hg_en: en at cycle %0d, want %0d", c, e);
                    end
                end
            end
            if (x !== 1'b0) bad_x = 1;
        end
        n_checks++;
        if (bad_x) begin
            n_fail++; $display("FAIL hg_x: x went high, want 0 throughout");
        end
        n_checks++;
        if (dwell !== 8'd4) begin
            n_fail++; $display("FAIL hg_dwell: dwell=%0d, want 4", dwell);
        end
        n_checks++;
        if (exp_tick.size() + exp_en.size() != 0) begin
            n_fail++; $display("FAIL hg_missing: %0d ticks and %0d en not seen",
                               exp_tick.size(), exp_en.size());
        end
    endtask

    task automatic test_sensor();
        int edges;
        int e;
        bit seen_x = 0;
        for (int pass = 0; pass < 2; pass++) begin
            car_raw = (pass == 0);
            exp_lat.push_back(DEB_CYCLES + 3);
            edges = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); edges++;
                @(negedge clk);
                if (x === car_raw) break;
            end
            e = exp_lat.pop_front();
            n_checks++;
            if (edges !== e || x !== car_raw) begin
                n_fail++; $display("FAIL sensor_latency: x=%b after %0d edges, want %b after %0d",
                                   x, edges, car_raw, e);
            end
        end
        car_raw = 1'b1;
        repeat (2) @(negedge clk);
        car_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (x !== 1'b0) seen_x = 1;
        end
        n_checks++;
        if (seen_x) begin
            n_fail++; $display("FAIL sensor_glitch: 2-cycle pulse reached x, want x=0");
        end
    endtask

    task automatic wait_en(input string name);
        int i;
        for (i = 0; i < 20; i++) begin
            if (en === 1'b1) break;
            @(negedge clk);
        end
        if (i == 20) begin
            n_checks++; n_fail++;
            $display("FAIL %s_wait_en: en not seen within 20 cycles, want en=1", name);
        end
    endtask

    task automatic test_hy();
        int e;
        car_raw = 1'b1;
        wait_en("hy");
        @(negedge clk);
        hwy = YEL; fwy = RED;
        @(negedge clk);
        n_checks++;
        if (dwell !== 8'd0) begin
            n_fail++; $display("FAIL hy_clear: dwell=%0d, want 0", dwell);
        end
        exp_en = '{8};
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) @(negedge clk);
            if (en) begin
                n_checks++;
                if (exp_en.size() == 0) begin
                    n_fail++; $display("FAIL hy_en: unexpected en at cycle %0d", c);
                end else begin
                    e = exp_en.pop_front();
                    if (c !== e) begin
                        n_fail++; $display("FAIL hy_en: en at cycle %0d, want %0d", c, e);
                    end
                end
            end
        end
        n_checks++;
        if (exp_en.size() != 0) begin
            n_fail++; $display("FAIL hy_missing: %0d en not seen", exp_en.size());
        end
    endtask

    task automatic test_fg_max();
        int e;
        bit bad_x = 0;
        wait_en("fg");
        @(negedge clk);
        hwy = RED; fwy = GRN;
        @(negedge clk);
        exp_en = '{8, 12, 16, 20, 24};
        for (int c = 0; c <= 24; c++) begin
            if (c > 0) @(negedge clk);
            if (en) begin
                n_checks++;
                if (exp_en.size() == 0) begin
                    n_fail++; $display("FAIL fg_en: unexpected en at cycle %0d", c);
                end else begin
                    e = exp_en.pop_front();
                    if (c !== e) begin
                        n_fail++; $display("FAIL fg_en: en at cycle %0d, want %0d", c, e);
                    end
                end
            end
            if (x !== (c <= 20)) begin
                if (!bad_x) $display("FAIL fg_x: x=%b at cycle %0d, want %b", x, c, (c <= 20));
                bad_x = 1;
            end
            if (c == 20) begin
                n_checks++;
                if (dwell !== 8'd5) begin
                    n_fail++; $display("FAIL fg_dwell: dwell=%0d at cycle 20, want 5", dwell);
                end
            end
        end
        n_checks++;
        if (bad_x) n_fail++;
        n_checks++;
        if (exp_en.size() != 0) begin
            n_fail++; $display("FAIL fg_missing: %0d en not seen", exp_en.size());
        end
    endtask

    task automatic test_fy_reset();
        int e;
        bit early_en = 0;
        @(negedge clk);
        hwy = RED; fwy = YEL;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            if (en) early_en = 1;
        end
        n_checks++;
        if (early_en || sec_tick !== 1'b1) begin
            n_fail++; $display("FAIL fy_pre: early_en=%b tick=%b at cycle 7, want 0 and 1",
                               early_en, sec_tick);
        end
        rstn = 1'b0;
        hwy = GRN; fwy = RED;
        #1;
        n_checks++;
        if ({en, x, dwell} !== 10'd0) begin
            n_fail++; $display("FAIL fy_async_reset: en=%b x=%b dwell=%0d, want 0 0 0", en, x, dwell);
        end
        @(negedge clk);
        n_checks++;
        if (en !== 1'b0) begin
            n_fail++; $display("FAIL fy_reset_en: en=%b in reset, want 0", en);
        end
        rstn = 1'b1;
        #1;
        exp_en = '{12};
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) @(negedge clk);
            if (en) begin
                n_checks++;
                if (exp_en.size() == 0) begin
                    n_fail++; $display("FAIL rst_en: unexpected en at cycle %0d", c);
                end else begin
                    e = exp_en.pop_front();
                    if (c !== e) begin
                        n_fail++; $display("FAIL rst_en: en at cycle %0d, want %0d", c, e);
                    end
                end
            end
            if (c == 5 || c == 6) begin
                n_checks++;
                if (x !== (c == 6)) begin
                    n_fail++; $display("FAIL rst_x: x=%b at cycle %0d, want %b", x, c, (c == 6));
                end
            end
        end
        n_checks++;
        if (exp_en.size() != 0) begin
            n_fail++; $display("FAIL rst_missing: %0d en not seen", exp_en.size());
        end
    endtask

    task automatic test_illegal();
        int e;
        bit bad = 0;
        hwy = RED; fwy = RED;
        n_checks++;
        if (phase_err !== 1'b0) begin
            n_fail++; $display("FAIL ill_pre: phase_err=%b, want 0", phase_err);
        end
        exp_tick = '{4, 8, 12, 16, 20};
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (phase_err !== 1'b1 || dwell !== 8'd0 || en !== 1'b0) begin
                if (!bad) $display("FAIL ill_hold: cycle %0d err=%b dwell=%0d en=%b, want 1 0 0",
                                   i, phase_err, dwell, en);
                bad = 1;
            end
            if (sec_tick) begin
                n_checks++;
                if (exp_tick.size() == 0) begin
                    n_fail++; $display("FAIL ill_tick: unexpected tick at cycle %0d", i);
                end else begin
                    e = exp_tick.pop_front();
                    if (i !== e) begin
                        n_fail++; $display("FAIL ill_tick: tick at cycle %0d, want %0d", i, e);
                    end
                end
            end
        end
        n_checks++;
        if (bad) n_fail++;
        n_checks++;
        if (exp_tick.size() != 0) begin
            n_fail++; $display("FAIL ill_missing: %0d ticks not seen", exp_tick.size());
        end
        hwy = GRN; fwy = RED;
        @(negedge clk);
        n_checks++;
        if (phase_err !== 1'b0) begin
            n_fail++; $display("FAIL ill_exit: phase_err=%b after HG, want 0", phase_err);
        end
    endtask

    initial begin
        test_reset();
        test_hg_timing();
        test_sensor();
        test_hy();
        test_fg_max();
        test_fy_reset();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
